// File: rtl/index_sum_reader_pkg.sv
// Shared definitions for the index-sum reader: FSM state encoding and default widths.
package index_sum_reader_pkg;

   localparam int DEF_SIZE_ADDR = 8;
   localparam int DEF_SIZE_DATA = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/index_sum_reader_if.sv
// Index handshake plus synchronous memory read port of the index-sum reader.
interface index_sum_reader_if #(
   parameter int SIZE_ADDR = 8,
   parameter int SIZE_DATA = 16,
   parameter int SIZE_SUM  = SIZE_DATA + SIZE_ADDR
) ();

   logic                 i_start;
   logic [SIZE_ADDR-1:0] i_num_elems;
   logic                 i_idx_valid;
   logic [SIZE_ADDR-1:0] i_idx;
   logic                 o_rd_en;
   logic [SIZE_ADDR-1:0] o_rd_addr;
   logic [SIZE_DATA-1:0] i_rd_data;
   logic [SIZE_SUM-1:0]  o_sum;
   logic                 o_valid;
   logic                 o_err;
   logic                 o_busy;

   modport slave (
      input  i_start, i_num_elems, i_idx_valid, i_idx, i_rd_data,
      output o_rd_en, o_rd_addr, o_sum, o_valid, o_err, o_busy
   );

   modport master (
      output i_start, i_num_elems, i_idx_valid, i_idx, i_rd_data,
      input  o_rd_en, o_rd_addr, o_sum, o_valid, o_err, o_busy
   );

endinterface

// File: rtl/index_sum_reader_rd_pipe_stage.sv
// Read-issue pipeline stage: valid bit plus address, flushable; address holds when idle.
module index_sum_reader_rd_pipe_stage #(
   parameter int SIZE_ADDR = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_load,
   input  logic [SIZE_ADDR-1:0] i_addr,
   output logic                 o_valid,
   output logic [SIZE_ADDR-1:0] o_addr
);

   logic                 valid_q, valid_d;
   logic [SIZE_ADDR-1:0] addr_q, addr_d;

   // Next-state: flush wins over load; the address is only replaced by a new read.
   always_comb begin
      valid_d = 1'b0;
      addr_d  = addr_q;
      if (i_flush) begin
         valid_d = 1'b0;
      end else if (i_load) begin
         valid_d = 1'b1;
         addr_d  = i_addr;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Stage registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= {SIZE_ADDR{1'b0}};
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign o_valid = valid_q;
   assign o_addr  = addr_q;

endmodule

// File: rtl/index_sum_reader.sv
// Accepts ordered element indices, reads one memory word per index and sums them.
module index_sum_reader
   import index_sum_reader_pkg::*;
#(
   parameter int SIZE_ADDR = DEF_SIZE_ADDR,
   parameter int SIZE_DATA = DEF_SIZE_DATA,
   parameter int SIZE_SUM  = SIZE_DATA + SIZE_ADDR
) (
   input logic               i_clk,
   input logic               i_rst_n,
   index_sum_reader_if.slave bus
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;
   localparam logic [SIZE_ADDR-1:0] ADDR_ONE = {{(SIZE_ADDR-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic [SIZE_ADDR-1:0] num_q, num_d, exp_q, exp_d, cnt_q, cnt_d;
   logic [SIZE_SUM-1:0]  sum_q, sum_d;
   logic                 err_q, err_d, valid_q, valid_d, busy_q, busy_d, dvld_q, dvld_d;
   logic                 accept_s, rd_en_s;
   logic [SIZE_ADDR-1:0] rd_addr_s;

   assign accept_s = (state_q == S_RUN) && bus.i_idx_valid && !bus.i_start;

   index_sum_reader_rd_pipe_stage #(.SIZE_ADDR(SIZE_ADDR)) u_rd_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (bus.i_start),
      .i_load  (accept_s),
      .i_addr  (bus.i_idx),
      .o_valid (rd_en_s),
      .o_addr  (rd_addr_s)
   );

   // FSM, ordering check and accumulation. DRAIN exits while the data stage is
   // still full, since its word is summed on the same edge that enters DONE.
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      err_d   = err_q;
      valid_d = 1'b0;
      dvld_d  = rd_en_s;
      if (bus.i_start) begin
         num_d  = bus.i_num_elems;
         exp_d  = {SIZE_ADDR{1'b0}};
         cnt_d  = {SIZE_ADDR{1'b0}};
         sum_d  = {SIZE_SUM{1'b0}};
         err_d  = 1'b0;
         dvld_d = 1'b0;
         if (bus.i_num_elems != {SIZE_ADDR{1'b0}}) begin
            state_d = S_RUN;
         end else begin
            state_d = S_DONE;
            valid_d = 1'b1;
         end
      end else begin
         if (dvld_q) begin
            sum_d = sum_q + {{(SIZE_SUM-SIZE_DATA){1'b0}}, bus.i_rd_data};
         end else begin
            sum_d = sum_q;
         end
         case (state_q)
            S_RUN: begin
               if (bus.i_idx_valid) begin
                  if (bus.i_idx != exp_q) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = err_q;
                  end
                  exp_d = exp_q + ADDR_ONE;
                  cnt_d = cnt_q + ADDR_ONE;
                  if (cnt_d == num_q) begin
                     state_d = S_DRAIN;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  state_d = S_RUN;
               end
            end
            S_DRAIN: begin
               if (!rd_en_s) begin
                  state_d = S_DONE;
                  valid_d = 1'b1;
               end else begin
                  state_d = S_DRAIN;
               end
            end
            S_IDLE:  state_d = S_IDLE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
   end

   // Control and result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         num_q   <= {SIZE_ADDR{1'b0}};
         exp_q   <= {SIZE_ADDR{1'b0}};
         cnt_q   <= {SIZE_ADDR{1'b0}};
         sum_q   <= {SIZE_SUM{1'b0}};
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         dvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         dvld_q  <= dvld_d;
      end
   end

   assign bus.o_rd_en   = rd_en_s;
   assign bus.o_rd_addr = rd_addr_s;
   assign bus.o_sum     = sum_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_err     = err_q;
   assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_index_sum_reader.sv
// Directed bench for index_sum_reader against a synchronous memory holding mem[k] = k+1.
module tb_index_sum_reader;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   index_sum_reader_if #(.SIZE_ADDR(8), .SIZE_DATA(16), .SIZE_SUM(24)) bus ();

   index_sum_reader #(.SIZE_ADDR(8), .SIZE_DATA(16), .SIZE_SUM(24)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read memory: word for the address presented now appears next cycle.
   always_ff @(posedge clk) begin
      bus.i_rd_data <= {8'h00, bus.o_rd_addr} + 16'd1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idx(input logic v, input logic [7:0] k);
      bus.i_idx_valid = v;
      bus.i_idx       = k;
      tick();
   endtask

   task automatic start(input logic [7:0] n);
      bus.i_start     = 1'b1;
      bus.i_num_elems = n;
      tick();
      bus.i_start     = 1'b0;
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst_n           = 1'b0;
      bus.i_start     = 1'b0;
      bus.i_num_elems = 8'd0;
      bus.i_idx_valid = 1'b0;
      bus.i_idx       = 8'd0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_rd_en", bus.o_rd_en, 1'b0);
      check("rst_sum", bus.o_sum, 24'd0);
      check("rst_valid", bus.o_valid, 1'b0);
      check("rst_busy", bus.o_busy, 1'b0);
      check("rst_err", bus.o_err, 1'b0);

      // N=4, indices back-to-back
      start(8'd4);
      check("n4_busy", bus.o_busy, 1'b1);
      idx(1'b1, 8'd0); check("n4_a0", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd0});
      idx(1'b1, 8'd1); check("n4_a1", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd1});
      idx(1'b1, 8'd2); check("n4_a2", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd2});
      idx(1'b1, 8'd3); check("n4_a3", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd3});
      check("n4_valid_t1", bus.o_valid, 1'b0);
      idx(1'b0, 8'd0);
      check("n4_rd_en_t2", bus.o_rd_en, 1'b0);
      check("n4_valid_t2", bus.o_valid, 1'b0);
      check("n4_sum_t2", bus.o_sum, 24'd6);
      check("n4_busy_t2", bus.o_busy, 1'b1);
      tick();
      check("n4_valid_t3", bus.o_valid, 1'b1);
      check("n4_sum", bus.o_sum, 24'd10);
      check("n4_err", bus.o_err, 1'b0);
      check("n4_busy_done", bus.o_busy, 1'b0);
      tick();
      check("n4_valid_once", bus.o_valid, 1'b0);
      check("n4_sum_hold", bus.o_sum, 24'd10);

      // N=0 completes immediately
      start(8'd0);
      check("n0_valid", bus.o_valid, 1'b1);
      check("n0_sum", bus.o_sum, 24'd0);
      check("n0_rd_en", bus.o_rd_en, 1'b0);
      check("n0_busy", bus.o_busy, 1'b0);
      tick();
      check("n0_valid_once", bus.o_valid, 1'b0);
      check("n0_rd_en_after", bus.o_rd_en, 1'b0);

      // N=3 out of order: 0,2,1
      start(8'd3);
      idx(1'b1, 8'd0); check("ooo_err0", bus.o_err, 1'b0);
      idx(1'b1, 8'd2); check("ooo_err1", bus.o_err, 1'b1);
      idx(1'b1, 8'd1);
      idx(1'b0, 8'd0);
      tick();
      check("ooo_valid", bus.o_valid, 1'b1);
      check("ooo_sum", bus.o_sum, 24'd6);
      check("ooo_err_done", bus.o_err, 1'b1);
      tick();
      check("ooo_err_hold", bus.o_err, 1'b1);
      start(8'd1);
      check("ooo_err_clr", bus.o_err, 1'b0);

      // N=3 with idle gaps: 0,_,_,1,_,2
      start(8'd3);
      idx(1'b1, 8'd0); check("gap_a0", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd0});
      idx(1'b0, 8'd9); check("gap_idle0", {bus.o_rd_en, bus.o_rd_addr}, {1'b0, 8'd0});
      idx(1'b0, 8'd9); check("gap_idle1", bus.o_rd_en, 1'b0);
      idx(1'b1, 8'd1); check("gap_a1", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd1});
      idx(1'b0, 8'd9); check("gap_idle2", {bus.o_rd_en, bus.o_rd_addr}, {1'b0, 8'd1});
      idx(1'b1, 8'd2); check("gap_a2", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd2});
      idx(1'b0, 8'd0); check("gap_valid_t2", bus.o_valid, 1'b0);
      tick();
      check("gap_valid_t3", bus.o_valid, 1'b1);
      check("gap_sum", bus.o_sum, 24'd6);
      check("gap_err", bus.o_err, 1'b0);

      // Restart N=5 after two indices, then N=2; same-cycle index ignored
      start(8'd5);
      idx(1'b1, 8'd0);
      idx(1'b1, 8'd1);
      bus.i_idx_valid = 1'b1;
      bus.i_idx       = 8'd7;
      start(8'd2);
      check("rs_rd_en", bus.o_rd_en, 1'b0);
      check("rs_sum_clr", bus.o_sum, 24'd0);
      check("rs_busy", bus.o_busy, 1'b1);
      idx(1'b1, 8'd0); check("rs_a0", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 8'd0});
      check("rs_sum_flushed", bus.o_sum, 24'd0);
      idx(1'b1, 8'd1);
      check("rs_sum_flushed2", bus.o_sum, 24'd0);
      idx(1'b0, 8'd0);
      tick();
      check("rs_valid", bus.o_valid, 1'b1);
      check("rs_sum", bus.o_sum, 24'd3);
      check("rs_err", bus.o_err, 1'b0);
      tick();
      check("rs_valid_once", bus.o_valid, 1'b0);

      // Asynchronous reset mid-pass
      start(8'd4);
      idx(1'b1, 8'd0);
      idx(1'b1, 8'd1);
      idx(1'b1, 8'd2);
      check("ar_pre_sum", bus.o_sum, 24'd1);
      check("ar_pre_addr", bus.o_rd_addr, 8'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_rd_en", bus.o_rd_en, 1'b0);
      check("ar_rd_addr", bus.o_rd_addr, 8'd0);
      check("ar_sum", bus.o_sum, 24'd0);
      check("ar_busy", bus.o_busy, 1'b0);
      check("ar_valid", bus.o_valid, 1'b0);
      #1;
      rst_n = 1'b1;
      idx(1'b1, 8'd0); check("ar_stray_rd0", bus.o_rd_en, 1'b0);
      idx(1'b1, 8'd5); check("ar_stray_rd1", bus.o_rd_en, 1'b0);
      check("ar_stray_err", bus.o_err, 1'b0);
      check("ar_stray_busy", bus.o_busy, 1'b0);
      bus.i_idx_valid = 1'b0;
      start(8'd1);
      idx(1'b1, 8'd0);
      idx(1'b0, 8'd0);
      tick();
      check("ar_post_valid", bus.o_valid, 1'b1);
      check("ar_post_sum", bus.o_sum, 24'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
